// File: rtl/pixel_window3x3.sv
// Line-buffered 3x3 neighbourhood generator: emits one interior window per accepted pixel.
// Optional WINDOW_LUMA_EN: sample is BT.601-style luma with one extra pipeline stage.
`timescale 1ns/1ps
module pixel_window3x3 #(
   parameter int LINE_W = 640,
   parameter int DW     = 8
) (
   input  logic            pclk,
   input  logic            rst_n,
   input  logic            frame_start,
   input  logic            pix_de,
   input  logic [23:0]     pix_in,
   output logic [9*DW-1:0] win,
   output logic            win_valid,
   output logic [10:0]     win_row,
   output logic [10:0]     win_col
);

   localparam int          AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [10:0] COL_LAST = 11'(LINE_W - 1);
   localparam logic [10:0] ROW_MAX  = 11'd2047;

   // Sample stream feeding the window core
   logic [DW-1:0] s;
   logic          in_de;
   logic          in_fs;

`ifdef WINDOW_LUMA_EN
   logic [15:0]   luma_d;
   logic [DW-1:0] s_d, s_q;
   logic          de_q, fs_q;

   always_comb begin
      luma_d = 16'd77  * {8'd0, pix_in[7:0]}
             + 16'd150 * {8'd0, pix_in[15:8]}
             + 16'd29  * {8'd0, pix_in[23:16]};
      s_d    = DW'(luma_d[15:8]);
   end

   // de and frame_start travel with the sample so counters stay aligned to it
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         s_q  <= '0;
         de_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         s_q  <= s_d;
         de_q <= pix_de;
         fs_q <= frame_start;
      end
   end

   assign s     = s_q;
   assign in_de = de_q;
   assign in_fs = fs_q;
`else
   logic unused_rb;
   assign unused_rb = ^{pix_in[23:16], pix_in[7:0]};
   assign s         = DW'(pix_in[15:8]);
   assign in_de     = pix_de;
   assign in_fs     = frame_start;
`endif

   logic [10:0]         col_q, col_d, row_q, row_d;
   logic [10:0]         col_cur, row_cur;
   logic [AW-1:0]       addr;
   logic [DW-1:0]       lb1_rd, lb0_rd;
   logic [2:0][DW-1:0]  top_q, top_d, mid_q, mid_d, bot_q, bot_d;
   logic                win_valid_q, win_valid_d;
   logic [10:0]         win_row_q, win_row_d, win_col_q, win_col_d;

   logic [DW-1:0] lb1_mem [LINE_W];
   logic [DW-1:0] lb0_mem [LINE_W];

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      col_cur     = in_fs ? 11'd0 : col_q;
      row_cur     = in_fs ? 11'd0 : row_q;
      addr        = col_cur[AW-1:0];
      lb1_rd      = lb1_mem[addr];
      lb0_rd      = lb0_mem[addr];
      col_d       = col_cur;
      row_d       = row_cur;
      top_d       = top_q;
      mid_d       = mid_q;
      bot_d       = bot_q;
      win_valid_d = 1'b0;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      if (in_de) begin
         if (col_cur == COL_LAST) begin
            col_d = 11'd0;
            row_d = (row_cur == ROW_MAX) ? row_cur : row_cur + 11'd1;
         end else begin
            col_d = col_cur + 11'd1;
         end
         top_d = {top_q[1:0], lb0_rd};
         mid_d = {mid_q[1:0], lb1_rd};
         bot_d = {bot_q[1:0], s};
         // Taps older than the current line start are stale until col reaches 2
         if (row_cur >= 11'd2 && col_cur >= 11'd2) begin
            win_valid_d = 1'b1;
            win_row_d   = row_cur - 11'd1;
            win_col_d   = col_cur - 11'd1;
         end
      end
   end

   // NOTE: line-buffer RAMs carry no reset; row<2 gating keeps their old contents hidden.
   always_ff @(posedge pclk) begin
      if (in_de) begin
         lb1_mem[addr] <= s;
         lb0_mem[addr] <= lb1_rd;
      end
   end

   // NOTE: state updates use <= so every flop samples pre-edge values.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         top_q       <= '0;
         mid_q       <= '0;
         bot_q       <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         top_q       <= top_d;
         mid_q       <= mid_d;
         bot_q       <= bot_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
      end
   end

   assign win       = {top_q, mid_q, bot_q};
   assign win_valid = win_valid_q;
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;

endmodule

// File: tb/tb_pixel_window3x3.sv
// Directed bench for pixel_window3x3 with LINE_W=8; gray pixels make luma equal the green value.
`timescale 1ns/1ps
module tb_pixel_window3x3;

   localparam int LINE_W = 8;
`ifdef WINDOW_LUMA_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        pix_de = 1'b0;
   logic [23:0] pix_in = '0;
   logic [71:0] win;
   logic        win_valid;
   logic [10:0] win_row, win_col;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mark_cyc = 0;

   typedef struct {
      logic [71:0] w;
      logic [10:0] r;
      logic [10:0] c;
      int          t;
   } obs_t;
   obs_t obs[$];

   pixel_window3x3 #(.LINE_W(LINE_W), .DW(8)) dut (
      .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start), .pix_de(pix_de),
      .pix_in(pix_in), .win(win), .win_valid(win_valid), .win_row(win_row),
      .win_col(win_col)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;
   always @(negedge pclk) if (win_valid === 1'b1) obs.push_back('{win, win_row, win_col, cyc});

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [71:0] exp_win(input logic [7:0] base, input int rc, input int cc);
      logic [71:0] w;
      w = '0;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++)
            w = {w[63:0], 8'(int'(base) + (rc - 1 + dy) * 16 + (cc - 1 + dx))};
      return w;
   endfunction

   task automatic drive_raw(input logic fs, input logic de, input logic [23:0] p);
      frame_start = fs;
      pix_de      = de;
      pix_in      = p;
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input logic fs, input logic de, input logic [7:0] v);
      drive_raw(fs, de, {v, v, v});
   endtask

   task automatic start_frame();
      drive(1'b1, 1'b0, 8'h00);
   endtask

   task automatic flush();
      repeat (4) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_span(input logic [7:0] base, input int r, input int c0, input int c1);
      for (int c = c0; c <= c1; c++) begin
         if (r == 2 && c == 2) mark_cyc = cyc;
         drive(1'b0, 1'b1, 8'(int'(base) + r * 16 + c));
      end
   endtask

   task automatic send_rows(input logic [7:0] base, input int n);
      for (int r = 0; r < n; r++) send_span(base, r, 0, LINE_W - 1);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (win !== '0) begin failures++; $display("FAIL reset_win: got %h expected 0", win); end
      checks++;
      if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", win_valid); end
      checks++;
      if (win_row !== '0 || win_col !== '0) begin
         failures++; $display("FAIL reset_rowcol: got %0d,%0d expected 0,0", win_row, win_col);
      end
      rst_n = 1'b1;
      @(posedge pclk);
      #1;
   endtask

   task automatic test_frame();
      int bad;
      obs.delete();
      start_frame();
      send_rows(8'h00, 4);
      flush();
      checks++;
      if (obs.size() != 12) begin failures++; $display("FAIL frame_count: got %0d expected 12", obs.size()); end
      if (obs.size() > 0) begin
         checks++;
         if (obs[0].w !== 72'h000102101112202122) begin
            failures++; $display("FAIL first_win: got %h expected 000102101112202122", obs[0].w);
         end
         checks++;
         if (obs[0].r !== 11'd1 || obs[0].c !== 11'd1) begin
            failures++; $display("FAIL first_pos: got %0d,%0d expected 1,1", obs[0].r, obs[0].c);
         end
         checks++;
         if (obs[0].t - mark_cyc != LAT) begin
            failures++; $display("FAIL first_latency: got %0d expected %0d", obs[0].t - mark_cyc, LAT);
         end
         checks++;
         if (obs[obs.size()-1].w[7:0] !== 8'h37) begin
            failures++; $display("FAIL last_w22: got %h expected 37", obs[obs.size()-1].w[7:0]);
         end
         checks++;
         if (obs[obs.size()-1].r !== 11'd2 || obs[obs.size()-1].c !== 11'd6) begin
            failures++;
            $display("FAIL last_pos: got %0d,%0d expected 2,6", obs[obs.size()-1].r, obs[obs.size()-1].c);
         end
         bad = 0;
         for (int i = 0; i < obs.size(); i++)
            if (obs[i].w !== exp_win(8'h00, 1 + i / 6, 1 + i % 6) ||
                obs[i].r !== 11'(1 + i / 6) || obs[i].c !== 11'(1 + i % 6)) bad++;
         checks++;
         if (bad != 0) begin failures++; $display("FAIL all_windows: got %0d bad expected 0 bad", bad); end
      end
   endtask

   task automatic test_stall();
      logic [71:0] hold;
      hold = 72'h010203111213212223;
      obs.delete();
      start_frame();
      send_rows(8'h00, 2);
      send_span(8'h00, 2, 0, 3);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 8'h00);
         if (i >= LAT - 1) begin
            checks++;
            if (win_valid !== 1'b0 || win !== hold) begin
               failures++; $display("FAIL stall_hold: got %b/%h expected 0/%h", win_valid, win, hold);
            end
         end
      end
      send_span(8'h00, 2, 4, LINE_W - 1);
      flush();
      checks++;
      if (obs.size() != 6) begin failures++; $display("FAIL stall_count: got %0d expected 6", obs.size()); end
      if (obs.size() > 2) begin
         checks++;
         if (obs[2].w[23:0] !== 24'h222324 || obs[2].c !== 11'd3) begin
            failures++; $display("FAIL stall_resume: got %h col %0d expected 222324 col 3", obs[2].w[23:0], obs[2].c);
         end
         checks++;
         if (obs[2].t - obs[1].t != 6) begin
            failures++; $display("FAIL stall_gap: got %0d expected 6", obs[2].t - obs[1].t);
         end
      end
   endtask

   task automatic test_frame_restart();
      obs.delete();
      start_frame();
      send_rows(8'h00, 3);
      send_span(8'h00, 3, 0, 2);
      start_frame();
      send_rows(8'h80, 3);
      flush();
      checks++;
      if (obs.size() != 13) begin failures++; $display("FAIL restart_count: got %0d expected 13", obs.size()); end
      if (obs.size() > 7) begin
         checks++;
         if (obs[6].r !== 11'd2 || obs[6].c !== 11'd1) begin
            failures++; $display("FAIL restart_old_last: got %0d,%0d expected 2,1", obs[6].r, obs[6].c);
         end
         checks++;
         if (obs[7].w !== exp_win(8'h80, 1, 1)) begin
            failures++; $display("FAIL restart_new_win: got %h expected %h", obs[7].w, exp_win(8'h80, 1, 1));
         end
         checks++;
         if (obs[7].t - mark_cyc != LAT) begin
            failures++; $display("FAIL restart_timing: got %0d expected %0d", obs[7].t - mark_cyc, LAT);
         end
      end
   endtask

   task automatic test_reset_mid();
      start_frame();
      send_rows(8'h00, 3);
      send_span(8'h00, 3, 0, 4);
      frame_start = 1'b0;
      pix_de      = 1'b0;
      checks++;
      if (win_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid: got %b expected 1", win_valid); end
      #1;
      rst_n = 1'b0;
      #1;
      obs.delete();
      checks++;
      if (win !== '0 || win_valid !== 1'b0 || win_row !== '0 || win_col !== '0) begin
         failures++;
         $display("FAIL async_reset: got %h/%b/%0d/%0d expected all 0", win, win_valid, win_row, win_col);
      end
      repeat (2) @(posedge pclk);
      #2;
      rst_n = 1'b1;
      @(posedge pclk);
      #1;
      start_frame();
      send_rows(8'h00, 3);
      flush();
      checks++;
      if (obs.size() != 6) begin failures++; $display("FAIL post_reset_count: got %0d expected 6", obs.size()); end
      if (obs.size() > 0) begin
         checks++;
         if (obs[0].t - mark_cyc != LAT || obs[0].w !== exp_win(8'h00, 1, 1)) begin
            failures++;
            $display("FAIL post_reset_first: got t%0d %h expected t%0d %h", obs[0].t - mark_cyc, obs[0].w, LAT, exp_win(8'h00, 1, 1));
         end
      end
   endtask

   task automatic test_row_sat();
      obs.delete();
      start_frame();
      send_rows(8'h00, 2049);
      flush();
      checks++;
      if (obs.size() != 12282) begin failures++; $display("FAIL sat_count: got %0d expected 12282", obs.size()); end
      if (obs.size() > 0) begin
         checks++;
         if (obs[obs.size()-1].r !== 11'd2046 || obs[obs.size()-1].c !== 11'd6) begin
            failures++;
            $display("FAIL sat_last: got %0d,%0d expected 2046,6", obs[obs.size()-1].r, obs[obs.size()-1].c);
         end
      end
   endtask

`ifdef WINDOW_LUMA_EN
   task automatic test_luma();
      start_frame();
      drive_raw(1'b0, 1'b1, 24'hFFFFFF);
      drive_raw(1'b0, 1'b1, 24'h0000FF);
      checks++;
      if (win[7:0] !== 8'hFF) begin failures++; $display("FAIL luma_white: got %h expected ff", win[7:0]); end
      drive_raw(1'b0, 1'b0, 24'h000000);
      checks++;
      if (win[7:0] !== 8'h4C) begin failures++; $display("FAIL luma_red: got %h expected 4c", win[7:0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_stall();
      test_frame_restart();
      test_reset_mid();
`ifdef WINDOW_LUMA_EN
      test_luma();
`endif
      test_row_sat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
